// File: rtl/seven_segment_pkg.sv
// Shared types and constants for the seven-segment BCD driver: FSM states,
// register map, and the active-high glyph table (segment order gfedcba).
package seven_segment_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } fsm_state_e;

  localparam logic [1:0] ADDR_VALUE   = 2'd0;
  localparam logic [1:0] ADDR_CONTROL = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // Index 0 is the rightmost entry: 0..9 then A b C d E F.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] glyph_lookup(input logic [3:0] nibble);
    return GLYPH_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seven_segment_encoder.sv
// Combinational nibble-to-glyph encoder, active-high output.
// Dash has priority over blank, which has priority over the nibble glyph.
module seven_segment_encoder
  import seven_segment_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] glyph
);

  // Select dash, blank or the table glyph
  always_comb begin
    glyph = SEG_BLANK;
    if (dash) begin
      glyph = SEG_DASH;
    end else if (blank) begin
      glyph = SEG_BLANK;
    end else begin
      glyph = glyph_lookup(nibble);
    end
  end

endmodule

// File: rtl/seven_segment_bcd_driver.sv
// Avalon-MM seven-segment driver: hex or double-dabble decimal display of VALUE.
// Blink gating of the display is built only when SEVEN_SEGMENT_BLINK_EN is defined.
module seven_segment_bcd_driver
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DATA_W         = 14,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int BLINK_DIV      = 25000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [NUM_DIGITS*7-1:0] seg_out,
  output logic                    busy
);

  localparam int BCD_W = NUM_DIGITS * 4;
  localparam int SEG_W = NUM_DIGITS * 7;
  localparam int SR_W  = BCD_W + DATA_W;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [31:0] MAX_DEC = 32'(10 ** NUM_DIGITS) - 32'd1;
  localparam logic [SEG_W-1:0] SEG_OFF =
    (SEG_ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};

  logic [DATA_W-1:0] value_r;
  logic [2:0]        control_r;
  fsm_state_e        state_r;
  logic [SR_W-1:0]   shift_r;
  logic [CNT_W-1:0]  count_r;
  logic              load_hex_r;
  logic              busy_r;
  logic              ovf_r;
  logic [SEG_W-1:0]  latch_r;
  logic [SEG_W-1:0]  seg_out_r;

  logic              wr_s;
  logic              wr_value_s;
  logic              wr_ctrl_s;
  logic              start_s;
  logic [DATA_W-1:0] start_value_s;
  logic              start_hex_s;
  logic [SR_W-1:0]   dabble_s;
  logic [SR_W-1:0]   shifted_s;
  logic [BCD_W-1:0]  hex_s;
  logic [BCD_W-1:0]  load_digits_s;
  logic              dash_s;
  logic [NUM_DIGITS-1:0] lz_blank_s;
  logic [SEG_W-1:0]  glyph_s;
  logic [SEG_W-1:0]  new_seg_s;
  logic              blink_off_s;

  // Bus write decode and the source of the next update
  always_comb begin
    wr_s       = chipselect & ~write_n;
    wr_value_s = wr_s & (address == ADDR_VALUE);
    wr_ctrl_s  = wr_s & (address == ADDR_CONTROL);
    start_s    = wr_value_s | wr_ctrl_s;
    if (wr_value_s) begin
      start_value_s = writedata[DATA_W-1:0];
    end else begin
      start_value_s = value_r;
    end
    if (wr_ctrl_s) begin
      start_hex_s = writedata[0];
    end else begin
      start_hex_s = control_r[0];
    end
  end

  // Host-visible VALUE and CONTROL registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_r   <= '0;
      control_r <= 3'd0;
    end else begin
      if (wr_value_s) value_r <= writedata[DATA_W-1:0];
      if (wr_ctrl_s) control_r <= writedata[2:0];
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_VALUE:   readdata[DATA_W-1:0] = value_r;
      ADDR_CONTROL: readdata[2:0]        = control_r;
      ADDR_STATUS:  readdata[1:0]        = {ovf_r, busy_r};
      default:      readdata             = 32'd0;
    endcase
  end

  // One double-dabble step: add 3 to each BCD nibble >= 5, then shift left
  always_comb begin
    dabble_s = shift_r;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (shift_r[DATA_W + 4*i +: 4] >= 4'd5) begin
        dabble_s[DATA_W + 4*i +: 4] = shift_r[DATA_W + 4*i +: 4] + 4'd3;
      end else begin
        dabble_s[DATA_W + 4*i +: 4] = shift_r[DATA_W + 4*i +: 4];
      end
    end
    shifted_s = dabble_s << 1;
  end

  assign hex_s  = BCD_W'({{BCD_W{1'b0}}, value_r});
  assign dash_s = ~load_hex_r & (32'(value_r) > MAX_DEC);

  // Digits presented to the encoders during LOAD
  always_comb begin
    if (load_hex_r) begin
      load_digits_s = hex_s;
    end else begin
      load_digits_s = shift_r[DATA_W +: BCD_W];
    end
  end

  // Leading-zero suppression; digit 0 always stays visible
  always_comb begin : p_lz
    logic zero_above;
    zero_above = 1'b1;
    lz_blank_s = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (load_digits_s[4*i +: 4] == 4'd0);
      if (control_r[1] && zero_above && (i != 0)) begin
        lz_blank_s[i] = 1'b1;
      end else begin
        lz_blank_s[i] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    seven_segment_encoder u_enc (
      .nibble (load_digits_s[4*g +: 4]),
      .blank  (lz_blank_s[g]),
      .dash   (dash_s),
      .glyph  (glyph_s[7*g +: 7])
    );
    // Board polarity is applied after encoding
    assign new_seg_s[7*g +: 7] =
      (SEG_ACTIVE_LOW != 0) ? ~glyph_s[7*g +: 7] : glyph_s[7*g +: 7];
  end

`ifdef SEVEN_SEGMENT_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLINK_W-1:0] blink_cnt_r;
  logic               phase_r;

  // Free-running blink divider; phase 1 means digits visible
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_r <= '0;
      phase_r     <= 1'b1;
    end else if (blink_cnt_r == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_r <= '0;
      phase_r     <= ~phase_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + 1'b1;
    end
  end

  assign blink_off_s = control_r[2] & ~phase_r;
`else
  assign blink_off_s = 1'b0;
`endif

  // Update FSM; a new write always restarts, and the display moves only in LOAD
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      shift_r    <= '0;
      count_r    <= '0;
      load_hex_r <= 1'b0;
      busy_r     <= 1'b0;
      ovf_r      <= 1'b0;
      latch_r    <= SEG_OFF;
      seg_out_r  <= SEG_OFF;
    end else begin
      seg_out_r <= blink_off_s ? SEG_OFF : latch_r;
      if (start_s) begin
        shift_r    <= {{BCD_W{1'b0}}, start_value_s};
        count_r    <= CNT_W'(DATA_W);
        load_hex_r <= start_hex_s;
        if (start_hex_s) begin
          state_r <= ST_LOAD;
          busy_r  <= 1'b0;
        end else begin
          state_r <= ST_SHIFT;
          busy_r  <= 1'b1;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            busy_r <= 1'b0;
          end
          ST_SHIFT: begin
            shift_r <= shifted_s;
            count_r <= count_r - CNT_W'(1);
            if (count_r == CNT_W'(1)) begin
              state_r <= ST_LOAD;
              busy_r  <= 1'b0;
            end else begin
              busy_r  <= 1'b1;
            end
          end
          ST_LOAD: begin
            latch_r   <= new_seg_s;
            seg_out_r <= blink_off_s ? SEG_OFF : new_seg_s;
            ovf_r     <= dash_s;
            busy_r    <= 1'b0;
            state_r   <= ST_IDLE;
          end
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign seg_out = seg_out_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_seven_segment_bcd_driver.sv
// Self-checking bench for seven_segment_bcd_driver (4 digits, 14-bit value, active-low).
// Expected displays come from a small reference model and flow through a scoreboard queue.
module tb_seven_segment_bcd_driver;

`ifdef SEVEN_SEGMENT_BLINK_EN
  localparam int BLINK_DIV_TB = 4;
`else
  localparam int BLINK_DIV_TB = 25000000;
`endif

  localparam logic [6:0] GLYPH_TB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [27:0] seg_out;
  logic        busy;

  typedef struct {
    logic [27:0] seg;
    int          lat;
    int          busy_cycles;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  seven_segment_bcd_driver #(
    .NUM_DIGITS(4), .DATA_W(14), .SEG_ACTIVE_LOW(1), .BLINK_DIV(BLINK_DIV_TB)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .seg_out(seg_out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] model_seg(input int unsigned v, input bit hex, input bit blz);
    int unsigned d [4];
    int unsigned p;
    logic [27:0] r;
    logic [6:0]  g;
    bit          zero_above;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      d[i] = hex ? ((v >> (4 * i)) & 32'd15) : ((v / p) % 10);
      p = p * 10;
    end
    zero_above = 1'b1;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      zero_above = zero_above && (d[i] == 0);
      if (!hex && v > 9999) g = 7'h40;
      else if (blz && zero_above && i != 0) g = 7'h00;
      else g = GLYPH_TB[d[i][3:0]];
      r[7*i +: 7] = ~g;
    end
    return r;
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  // Watches the display after a write; lat stays 0 if it never changes
  task automatic observe(input logic [27:0] forbid, output int lat, output int busy_cnt,
                         output logic [27:0] seg_final, output bit saw_forbid);
    logic [27:0] prev;
    prev = seg_out; lat = 0; busy_cnt = 0; saw_forbid = 1'b0;
    for (int k = 0; k <= 24; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (lat == 0 && k > 0 && seg_out !== prev) lat = k;
      if (lat == 0 && busy === 1'b1) busy_cnt++;
      if (seg_out === forbid) saw_forbid = 1'b1;
    end
    seg_final = seg_out;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (seg_out !== 28'hFFFFFFF) begin
      n_bad++; $display("FAIL reset_seg: got %h want %h", seg_out, 28'hFFFFFFF);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    bus_read(2'd2, rd);
    n_cmp++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL reset_status: got %h want 0", rd); end
    n_cmp++;
    if (seg_out !== 28'hFFFFFFF) begin
      n_bad++; $display("FAIL reset_seg_after: got %h want %h", seg_out, 28'hFFFFFFF);
    end
  endtask

  task automatic test_decimal();
    int unsigned vals [3] = '{1234, 0, 407};
    int lat, bc;
    logic [27:0] fin;
    bit sf;
    exp_t e;
    foreach (vals[i]) begin
      exp_q.push_back('{model_seg(vals[i], 1'b0, 1'b0), 15, 14});
      bus_write(2'd0, vals[i]);
      observe(28'h0, lat, bc, fin, sf);
      e = exp_q.pop_front();
      n_cmp++;
      if (fin !== e.seg) begin n_bad++; $display("FAIL dec_seg[%0d]: got %h want %h", vals[i], fin, e.seg); end
      n_cmp++;
      if (lat !== e.lat) begin n_bad++; $display("FAIL dec_latency[%0d]: got %0d want %0d", vals[i], lat, e.lat); end
      n_cmp++;
      if (bc !== e.busy_cycles) begin n_bad++; $display("FAIL dec_busy[%0d]: got %0d want %0d", vals[i], bc, e.busy_cycles); end
    end
  endtask

  task automatic test_hex();
    logic [31:0] wa [3] = '{32'd1, 32'd0, 32'd0};
    logic [31:0] wd [3] = '{32'd1, 32'h2BEF, 32'h00A5};
    int unsigned mv [3] = '{407, 32'h2BEF, 32'h00A5};
    int lat, bc;
    logic [27:0] fin;
    logic [31:0] rd;
    bit sf;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{model_seg(mv[i], 1'b1, 1'b0), 1, 0});
      bus_write(wa[i][1:0], wd[i]);
      observe(28'h0, lat, bc, fin, sf);
      e = exp_q.pop_front();
      n_cmp++;
      if (fin !== e.seg) begin n_bad++; $display("FAIL hex_seg[%0d]: got %h want %h", i, fin, e.seg); end
      n_cmp++;
      if (lat !== e.lat) begin n_bad++; $display("FAIL hex_latency[%0d]: got %0d want %0d", i, lat, e.lat); end
      n_cmp++;
      if (bc !== e.busy_cycles) begin n_bad++; $display("FAIL hex_busy[%0d]: got %0d want %0d", i, bc, e.busy_cycles); end
    end
    bus_read(2'd1, rd);
    n_cmp++;
    if (rd !== 32'd1) begin n_bad++; $display("FAIL hex_ctrl_readback: got %h want 1", rd); end
  endtask

  task automatic test_overflow();
    int lat, bc;
    logic [27:0] fin;
    logic [31:0] rd;
    bit sf;
    exp_t e;
    exp_q.push_back('{model_seg(12000, 1'b1, 1'b0), 1, 0});
    bus_write(2'd0, 32'd12000);
    observe(28'h0, lat, bc, fin, sf);
    e = exp_q.pop_front();
    n_cmp++;
    if (fin !== e.seg) begin n_bad++; $display("FAIL ovf_hex_seg: got %h want %h", fin, e.seg); end
    exp_q.push_back('{model_seg(12000, 1'b0, 1'b0), 15, 14});
    bus_write(2'd1, 32'd0);
    observe(28'h0, lat, bc, fin, sf);
    e = exp_q.pop_front();
    n_cmp++;
    if (fin !== e.seg) begin n_bad++; $display("FAIL ovf_dash_seg: got %h want %h", fin, e.seg); end
    n_cmp++;
    if (lat !== e.lat) begin n_bad++; $display("FAIL ovf_latency: got %0d want %0d", lat, e.lat); end
    bus_read(2'd2, rd);
    n_cmp++;
    if (rd !== 32'd2) begin n_bad++; $display("FAIL ovf_status_set: got %h want 2", rd); end
    bus_write(2'd1, 32'd2);
    repeat (20) @(posedge clk);
    #1;
    exp_q.push_back('{model_seg(42, 1'b0, 1'b1), 15, 14});
    bus_write(2'd0, 32'd42);
    observe(28'h0, lat, bc, fin, sf);
    e = exp_q.pop_front();
    n_cmp++;
    if (fin !== e.seg) begin n_bad++; $display("FAIL blz_seg: got %h want %h", fin, e.seg); end
    bus_read(2'd2, rd);
    n_cmp++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL ovf_status_clear: got %h want 0", rd); end
    bus_read(2'd0, rd);
    n_cmp++;
    if (rd !== 32'd42) begin n_bad++; $display("FAIL value_readback: got %h want 42", rd); end
    bus_read(2'd1, rd);
    n_cmp++;
    if (rd !== 32'd2) begin n_bad++; $display("FAIL ctrl_readback: got %h want 2", rd); end
    bus_read(2'd3, rd);
    n_cmp++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL reserved_read: got %h want 0", rd); end
  endtask

  task automatic test_restart();
    int lat, bc;
    logic [27:0] fin;
    bit sf;
    exp_t e;
    exp_q.push_back('{model_seg(42, 1'b0, 1'b0), 15, 14});
    bus_write(2'd1, 32'd0);
    observe(28'h0, lat, bc, fin, sf);
    e = exp_q.pop_front();
    n_cmp++;
    if (fin !== e.seg) begin n_bad++; $display("FAIL restart_pre_seg: got %h want %h", fin, e.seg); end
    bus_write(2'd0, 32'd9999);
    repeat (5) @(posedge clk);
    #1;
    exp_q.push_back('{model_seg(5, 1'b0, 1'b0), 15, 14});
    bus_write(2'd0, 32'd5);
    observe(model_seg(9999, 1'b0, 1'b0), lat, bc, fin, sf);
    e = exp_q.pop_front();
    n_cmp++;
    if (fin !== e.seg) begin n_bad++; $display("FAIL restart_seg: got %h want %h", fin, e.seg); end
    n_cmp++;
    if (lat !== e.lat) begin n_bad++; $display("FAIL restart_latency: got %0d want %0d", lat, e.lat); end
    n_cmp++;
    if (sf !== 1'b0) begin n_bad++; $display("FAIL restart_no_9999: got %b want 0", sf); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    bus_write(2'd0, 32'd1234);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (seg_out !== 28'hFFFFFFF) begin n_bad++; $display("FAIL midreset_seg: got %h want %h", seg_out, 28'hFFFFFFF); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if (seg_out !== 28'hFFFFFFF) begin n_bad++; $display("FAIL midreset_seg_hold: got %h want %h", seg_out, 28'hFFFFFFF); end
    bus_read(2'd0, rd);
    n_cmp++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL midreset_value: got %h want 0", rd); end
  endtask

  task automatic test_blink();
    int lat, bc;
    logic [27:0] fin;
    logic [27:0] s [16];
    logic [27:0] vis;
    bit sf;
    exp_t e;
    vis = model_seg(7, 1'b0, 1'b0);
    exp_q.push_back('{vis, 15, 14});
    bus_write(2'd0, 32'd7);
    observe(28'h0, lat, bc, fin, sf);
    e = exp_q.pop_front();
    n_cmp++;
    if (fin !== e.seg) begin n_bad++; $display("FAIL blink_pre_seg: got %h want %h", fin, e.seg); end
    bus_write(2'd1, 32'd4);
    repeat (20) @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      s[k] = seg_out;
    end
`ifdef SEVEN_SEGMENT_BLINK_EN
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if (!((s[k] === 28'hFFFFFFF && s[k+4] === vis) || (s[k] === vis && s[k+4] === 28'hFFFFFFF))) begin
        n_bad++; $display("FAIL blink_alt[%0d]: got %h then %h want alternating %h/blank", k, s[k], s[k+4], vis);
      end
    end
`else
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (s[k] !== vis) begin n_bad++; $display("FAIL blink_steady[%0d]: got %h want %h", k, s[k], vis); end
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    test_reset();
    test_decimal();
    test_hex();
    test_overflow();
    test_restart();
    test_reset_mid();
    test_blink();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
